fwft_rr_scheduler: RTL and testbench
====================================

// Module: fwft_rr_scheduler
// PURPOSE
//   Round-robin burst scheduler that drains NUM_SRC first-word-fall-through read ports into one
//   valid/ready stream. Sits between the per-producer FWFT read wrappers and the single downstream
//   consumer. Generates each wrapper's rd_enable and tags every beat with its source index.
//   Bounds each grant to BURST_LEN beats for fairness.
// PARAMETERS
//   NUM_SRC    4   number of FWFT sources (2..8)
//   DW         8   data width per source
//   BURST_LEN  4   max beats per grant (1..255)
// PORTS
//   rclk       in   1            read-domain clock
//   rrst_n     in   1            reset, asynchronous, active-low
//   src_empty  in   NUM_SRC      FWFT empty per source; 0 => src_data slice valid now
//   src_data   in   NUM_SRC*DW   FWFT head data; source i at [i*DW +: DW]
//   src_rd_en  out  NUM_SRC      pop strobe per source; one-hot or zero
//   m_valid    out  1            output beat valid
//   m_ready    in   1            downstream accepts beat
//   m_data     out  DW           beat data
//   m_src      out  $clog2(NUM_SRC)  source index of beat
//   m_last     out  1            final beat of current grant
// BEHAVIOUR
//   - Reset: state=IDLE, grant=0, last_grant=NUM_SRC-1 (src 0 has first priority), beat_cnt=0,
//     so src_rd_en=0, m_valid=0, m_last=0, m_src=0, m_data=0.
//   - FSM IDLE: if any src_empty==0, pick the first non-empty index scanning
//     last_grant+1, +2, ... with modulo wrap. Register it as grant, beat_cnt<=0, go to BURST.
//     Otherwise stay IDLE. No beat is issued in IDLE (1-cycle arbitration bubble).
//   - FSM BURST: combinational passthrough. m_valid=~src_empty[grant], m_data=src_data[grant],
//     m_src=grant, m_last=m_valid & (beat_cnt==BURST_LEN-1).
//     src_rd_en[grant]=m_valid & m_ready; all other bits 0.
//   - Transfer = m_valid & m_ready: beat_cnt++.
//   - Burst end: return to IDLE and set last_grant<=grant on either
//     (a) a transfer with beat_cnt==BURST_LEN-1, or
//     (b) src_empty[grant]==1 while in BURST (source ran dry; no transfer that cycle).
//   - m_ready low with m_valid high: m_data/m_src/m_last held stable (the FWFT head does not move),
//     and the grant is held indefinitely.
//   - A source that goes non-empty mid-burst on another index waits for rotation.
//     The granted source refilling keeps the burst alive.
//   - The cycle after src_rd_en, src_empty may be 1 transiently; rule (b) ends the burst.
//     This is accepted (costs one re-arbitration).
//   - Asserting rrst_n low mid-burst: immediate async return to reset values; no pop is issued.
//   - beat_cnt width is 8 bits and never exceeds BURST_LEN-1.
// CONFIGURATION
//   Macro FWFT_SCHED_XFER_CNT_EN:
//   - Defined: adds input cnt_clr (1) and output xfer_cnt (NUM_SRC*16).
//     Each 16-bit counter increments on every transfer from its source and wraps at 0xFFFF->0.
//     cnt_clr (synchronous) zeroes all counters; a clear wins over a same-cycle increment.
//     Counters reset to 0.
//   - Undefined: ports and counters absent; scheduling behaviour identical.
// STRUCTURE
//   - Shared package fwft_sched_pkg: state encoding (ST_IDLE=1'b0, ST_BURST=1'b1),
//     counter width constant XFER_CNT_W=16.
//   - Sub-module rr_pick: combinational round-robin priority picker.
//     Inputs: req vector, last index. Outputs: any, idx. Instantiated once.
//   - The remainder (FSM, beat counter, output muxing, optional counters) lives in this module.
// TESTING
//   1. Reset release, all src_empty=1 -> m_valid=0, src_rd_en=0 for 20 cycles.
//   2. Src1 holds 6 words (0x10..0x15), m_ready=1, BURST_LEN=4
//      -> beats 0x10..0x13 with m_src=1, m_last on 0x13, one IDLE bubble,
//      then 0x14,0x15 as a second grant.
//   3. All 4 sources non-empty continuously -> grant order 0,1,2,3,0,... with 4 beats each;
//      no source is skipped.
//   4. m_ready toggles 1,0,0,1 on src2 -> src_rd_en[2] only on ready cycles;
//      m_data stable while stalled; 4 beats delivered in order, none duplicated.
//   5. Src0 empties after 2 beats mid-burst -> FSM returns to IDLE;
//      next grant goes to src1 (if non-empty), not src0.
//   6. Reset asserted mid-burst -> m_valid=0 and src_rd_en=0 immediately.
//      With FWFT_SCHED_XFER_CNT_EN defined: after scenario 3 runs 8 rounds, xfer_cnt[i]=32
//      for every i; cnt_clr then zeroes all counters.

Source files
------------

// File: rtl/fwft_sched_pkg.sv
// Shared definitions for the FWFT round-robin scheduler: FSM encoding and
// the width of the optional per-source transfer counters.
package fwft_sched_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requesting index found
// scanning last+1, last+2, ... with wrap, so 'last' itself has lowest priority.
module rr_pick
   import fwft_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          any,
   output logic [IW-1:0] idx
);

   always_comb begin
      logic          found;
      int            cand;
      logic [IW-1:0] cand_idx;
      any      = |req;
      idx      = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 1; k <= N; k++) begin
         cand     = (int'(last) + k) % N;
         cand_idx = IW'(cand);
         if (!found && req[cand_idx]) begin
            idx   = cand_idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fwft_rr_scheduler.sv
// Round-robin burst scheduler draining NUM_SRC FWFT read ports into one valid/ready stream.
// Optional per-source transfer counters are enabled with the macro FWFT_SCHED_XFER_CNT_EN.
module fwft_rr_scheduler
   import fwft_sched_pkg::*;
#(
   parameter int  NUM_SRC   = 4,
   parameter int  DW        = 8,
   parameter int  BURST_LEN = 4,
   localparam int SW        = $clog2(NUM_SRC)
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic [NUM_SRC-1:0]    src_empty,
   input  logic [NUM_SRC*DW-1:0] src_data,
   output logic [NUM_SRC-1:0]    src_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DW-1:0]         m_data,
   output logic [SW-1:0]         m_src,
   output logic                  m_last
`ifdef FWFT_SCHED_XFER_CNT_EN
   ,
   input  logic                          cnt_clr,
   output logic [NUM_SRC*XFER_CNT_W-1:0] xfer_cnt
`endif
);

   state_t        state, state_nxt;
   logic [SW-1:0] grant, grant_nxt;
   logic [SW-1:0] last_grant, last_grant_nxt;
   logic [7:0]    beat_cnt, beat_cnt_nxt;
   logic          pick_any;
   logic [SW-1:0] pick_idx;
   logic          head_empty;
   logic [DW-1:0] head_data;
   logic          in_burst;
   logic          final_beat;
   logic          xfer;

   rr_pick #(
      .N  (NUM_SRC),
      .IW (SW)
   ) u_pick (
      .req  (~src_empty),
      .last (last_grant),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   always_comb begin
      head_empty = 1'b1;
      head_data  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant == SW'(i)) begin
            head_empty = src_empty[i];
            head_data  = src_data[i*DW +: DW];
         end
      end
   end

   // The granted FWFT head passes straight through; a stall simply leaves it in place.
   always_comb begin
      in_burst   = (state == ST_BURST);
      m_valid    = in_burst & ~head_empty;
      m_data     = in_burst ? head_data : '0;
      m_src      = in_burst ? grant : '0;
      final_beat = (beat_cnt == 8'(BURST_LEN - 1));
      m_last     = m_valid & final_beat;
      xfer       = m_valid & m_ready;
      src_rd_en  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (xfer && (grant == SW'(i))) begin
            src_rd_en[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      beat_cnt_nxt   = beat_cnt;
      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               state_nxt    = ST_BURST;
               grant_nxt    = pick_idx;
               beat_cnt_nxt = '0;
            end
         end
         ST_BURST: begin
            // A dry source ends the grant early so others are not blocked by an idle producer.
            if (head_empty) begin
               state_nxt      = ST_IDLE;
               last_grant_nxt = grant;
            end else if (xfer) begin
               if (final_beat) begin
                  state_nxt      = ST_IDLE;
                  last_grant_nxt = grant;
                  beat_cnt_nxt   = '0;
               end else begin
                  beat_cnt_nxt = beat_cnt + 8'd1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state      <= ST_IDLE;
         grant      <= '0;
         last_grant <= SW'(NUM_SRC - 1);
         beat_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
         beat_cnt   <= beat_cnt_nxt;
      end
   end

`ifdef FWFT_SCHED_XFER_CNT_EN
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         xfer_cnt <= '0;
      end else if (cnt_clr) begin
         xfer_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (src_rd_en[i]) begin
               xfer_cnt[i*XFER_CNT_W +: XFER_CNT_W] <= xfer_cnt[i*XFER_CNT_W +: XFER_CNT_W] + 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_fwft_rr_scheduler.sv
// Randomized scoreboard bench for fwft_rr_scheduler: per-source FWFT queues feed the DUT,
// a queue-based round-robin reference predicts every cycle, a monitor compares.
module tb_fwft_rr_scheduler;

   localparam int NUM_SRC = 4;
   localparam int DW      = 8;
   localparam int BL      = 4;
   localparam int SW      = 2;

   typedef struct {
      logic               valid;
      logic [DW-1:0]      data;
      logic [SW-1:0]      src;
      logic               last;
      logic [NUM_SRC-1:0] rd_en;
   } exp_t;

   logic                  rclk;
   logic                  rrst_n;
   logic [NUM_SRC-1:0]    src_empty;
   logic [NUM_SRC*DW-1:0] src_data;
   logic [NUM_SRC-1:0]    src_rd_en;
   logic                  m_valid;
   logic                  m_ready;
   logic [DW-1:0]         m_data;
   logic [SW-1:0]         m_src;
   logic                  m_last;
`ifdef FWFT_SCHED_XFER_CNT_EN
   logic                  cnt_clr;
   logic [NUM_SRC*16-1:0] xfer_cnt;
`endif

   int                 compared   = 0;
   int                 mismatched = 0;
   exp_t               exp_q[$];
   logic [DW-1:0]      fifo[NUM_SRC][$];
   logic [DW-1:0]      mq[NUM_SRC][$];
   logic [NUM_SRC-1:0] seen_rd_en = '0;
   logic [DW-1:0]      next_word  = 8'h40;
   int                 mcur       = -1;
   int                 mprev      = NUM_SRC - 1;
   int                 mtaken     = 0;
   int                 mcnt[NUM_SRC];

   fwft_rr_scheduler #(
      .NUM_SRC   (NUM_SRC),
      .DW        (DW),
      .BURST_LEN (BL)
   ) dut (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .src_empty (src_empty),
      .src_data  (src_data),
      .src_rd_en (src_rd_en),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_src     (m_src),
      .m_last    (m_last)
`ifdef FWFT_SCHED_XFER_CNT_EN
      ,
      .cnt_clr   (cnt_clr),
      .xfer_cnt  (xfer_cnt)
`endif
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int pickNext();
      for (int k = 1; k <= NUM_SRC; k++) begin
         int c;
         c = (mprev + k) % NUM_SRC;
         if (mq[c].size() > 0) return c;
      end
      return -1;
   endfunction

   // Reference: one arbitration cycle with no beat, then up to BL beats from the winner,
   // ending early the first cycle the winner has nothing to offer.
   task automatic modelStep();
      exp_t e;
      e.valid = 1'b0;
      e.data  = '0;
      e.src   = '0;
      e.last  = 1'b0;
      e.rd_en = '0;
      if (mcur < 0) begin
         mcur   = pickNext();
         mtaken = 0;
      end else if (mq[mcur].size() == 0) begin
         mprev = mcur;
         mcur  = -1;
      end else begin
         e.valid = 1'b1;
         e.data  = mq[mcur][0];
         e.src   = SW'(mcur);
         e.last  = (mtaken == BL - 1);
         if (m_ready) begin
            e.rd_en = NUM_SRC'(1) << mcur;
            void'(mq[mcur].pop_front());
            mcnt[mcur] = (mcnt[mcur] + 1) % 65536;
            mtaken++;
            if (mtaken == BL) begin
               mprev = mcur;
               mcur  = -1;
            end
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic driveInputs();
      for (int i = 0; i < NUM_SRC; i++) begin
         src_empty[i] = (fifo[i].size() == 0);
         src_data[i*DW +: DW] = (fifo[i].size() > 0) ? fifo[i][0] : DW'($urandom);
      end
   endtask

   task automatic loadSource(input int s, input logic [DW-1:0] base, input int n);
      for (int k = 0; k < n; k++) begin
         fifo[s].push_back(base + DW'(k));
         mq[s].push_back(base + DW'(k));
      end
   endtask

   task automatic applyStimulus(input int cycles, input int push_pct, input int ready_pct);
      repeat (cycles) begin
         @(negedge rclk);
         for (int i = 0; i < NUM_SRC; i++) begin
            if (seen_rd_en[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
         end
         for (int i = 0; i < NUM_SRC; i++) begin
            if (int'($urandom_range(99)) < push_pct) begin
               fifo[i].push_back(next_word);
               mq[i].push_back(next_word);
               next_word = next_word + 8'd1;
            end
         end
         m_ready = (int'($urandom_range(99)) < ready_pct);
         driveInputs();
         modelStep();
      end
   endtask

   function automatic bit allEmpty();
      for (int i = 0; i < NUM_SRC; i++) begin
         if (fifo[i].size() != 0 || mq[i].size() != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Monitor: compares the DUT against the oldest prediction, well clear of the rising edge.
   always @(negedge rclk) begin
      exp_t e;
      #2;
      seen_rd_en = src_rd_en;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput("m_valid", 32'(m_valid), 32'(e.valid));
         checkOutput("src_rd_en", 32'(src_rd_en), 32'(e.rd_en));
         if (e.valid) begin
            checkOutput("m_data", 32'(m_data), 32'(e.data));
            checkOutput("m_src", 32'(m_src), 32'(e.src));
            checkOutput("m_last", 32'(m_last), 32'(e.last));
         end
      end
   end

   initial begin
      rrst_n    = 1'b0;
      m_ready   = 1'b0;
      src_empty = '1;
      src_data  = '0;
`ifdef FWFT_SCHED_XFER_CNT_EN
      cnt_clr   = 1'b0;
`endif
      for (int i = 0; i < NUM_SRC; i++) mcnt[i] = 0;
      #3;
      checkOutput("reset m_valid", 32'(m_valid), 0);
      checkOutput("reset src_rd_en", 32'(src_rd_en), 0);
      checkOutput("reset m_last", 32'(m_last), 0);
      checkOutput("reset m_src", 32'(m_src), 0);
      checkOutput("reset m_data", 32'(m_data), 0);
      @(posedge rclk);
      #1 rrst_n = 1'b1;

      $display("[TB] all sources empty");
      applyStimulus(20, 0, 100);
      $display("[TB] single source, six words");
      loadSource(1, 8'h10, 6);
      applyStimulus(16, 0, 100);
      $display("[TB] all sources busy");
      for (int i = 0; i < NUM_SRC; i++) loadSource(i, 8'h80 + DW'(i * 16), 16);
      applyStimulus(40, 0, 100);
      $display("[TB] random traffic with backpressure");
      applyStimulus(400, 10, 70);
      applyStimulus(200, 15, 50);

      $display("[TB] reset mid-burst");
      loadSource(2, 8'hA0, 8);
      applyStimulus(3, 0, 100);
      @(negedge rclk);
      for (int i = 0; i < NUM_SRC; i++) begin
         if (seen_rd_en[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
      end
      m_ready = 1'b1;
      driveInputs();
      #1 rrst_n = 1'b0;
      #1;
      checkOutput("midreset m_valid", 32'(m_valid), 0);
      checkOutput("midreset src_rd_en", 32'(src_rd_en), 0);
      checkOutput("midreset m_last", 32'(m_last), 0);
      mcur   = -1;
      mprev  = NUM_SRC - 1;
      mtaken = 0;
      for (int i = 0; i < NUM_SRC; i++) mcnt[i] = 0;
      repeat (2) @(posedge rclk);
      #1 rrst_n = 1'b1;
      applyStimulus(200, 10, 60);

      $display("[TB] drain");
      for (int n = 0; n < 100 && !allEmpty(); n++) applyStimulus(10, 0, 100);
      applyStimulus(6, 0, 100);
      for (int i = 0; i < NUM_SRC; i++) checkOutput("drained fifo size", 32'(fifo[i].size()), 0);

`ifdef FWFT_SCHED_XFER_CNT_EN
      @(negedge rclk);
      for (int i = 0; i < NUM_SRC; i++) checkOutput("xfer_cnt", 32'(xfer_cnt[i*16 +: 16]), 32'(mcnt[i]));
      cnt_clr = 1'b1;
      @(negedge rclk);
      cnt_clr = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) checkOutput("xfer_cnt cleared", 32'(xfer_cnt[i*16 +: 16]), 0);
`endif

      @(negedge rclk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
